// File: rtl/pipelined_add_sub_if.sv
// Handshake and data bundle for the pipelined adder/subtractor.
// The slave modport is the adder's view of the bundle.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Segmented add/subtract: one SEG-bit slice per stage with the carry registered between
// stages. The whole pipeline advances together whenever the output slot is free.
module pipelined_add_sub #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int NSTAGE = WIDTH / SEG;

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign accept       = bus.in_valid && adv;

    // Subtraction is a + ~b + ~borrow_in, so carry_out = 1 means no borrow.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? ~bus.carry_in : bus.carry_in;

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : stg
            // Operand bits still to be consumed when entering this stage.
            localparam int SW = WIDTH - gi * SEG;

            logic [SW-1:0]    src_a;
            logic [SW-1:0]    src_b;
            logic             src_c;
            logic             src_v;
            logic [WIDTH-1:0] src_res;
            logic [SEG:0]     seg_sum;
            logic [WIDTH-1:0] res_d;
            logic             vld_q;
            logic             cy_q;
            logic [WIDTH-1:0] res_q;

            if (gi == 0) begin : g_src
                assign src_a   = bus.a;
                assign src_b   = b_eff;
                assign src_c   = c0;
                assign src_v   = accept;
                assign src_res = '0;
            end else begin : g_src
                assign src_a   = stg[gi-1].g_op.opa_q;
                assign src_b   = stg[gi-1].g_op.opb_q;
                assign src_c   = stg[gi-1].cy_q;
                assign src_v   = stg[gi-1].vld_q;
                assign src_res = stg[gi-1].res_q;
            end

            assign seg_sum = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]}
                           + {{SEG{1'b0}}, src_c};

            always_comb begin
                res_d = src_res;
                res_d[gi*SEG +: SEG] = seg_sum[SEG-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    res_q <= '0;
                end else if (adv) begin
                    vld_q <= src_v;
                    cy_q  <= seg_sum[SEG];
                    res_q <= res_d;
                end
            end

            if (gi < NSTAGE - 1) begin : g_op
                // Only the not-yet-added upper slices travel on, shifted down.
                logic [SW-SEG-1:0] opa_q;
                logic [SW-SEG-1:0] opb_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        opa_q <= '0;
                        opb_q <= '0;
                    end else if (adv) begin
                        opa_q <= src_a[SW-1:SEG];
                        opb_q <= src_b[SW-1:SEG];
                    end
                end
            end else begin : g_out
                logic ovf_d;
                logic zero_d;
                logic ovf_q;
                logic zero_q;

                // Top slice holds the operand MSBs, so signed overflow is decided here.
                assign ovf_d  = (src_a[SEG-1] == src_b[SEG-1])
                             && (seg_sum[SEG-1] != src_a[SEG-1]);
                assign zero_d = (res_d == '0);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q  <= 1'b0;
                        zero_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q  <= ovf_d;
                        zero_q <= zero_d;
                    end
                end

                assign bus.out_valid = vld_q;
                assign bus.sum       = res_q;
                assign bus.carry_out = cy_q;
                assign bus.overflow  = ovf_q;
                assign bus.zero      = zero_q;
            end
        end
    endgenerate
endmodule
